aes_sub_bytes_unit: RTL and testbench

- Registered AES byte-substitution stage for the AES datapath.
- Applies either the forward S-box (SubBytes) or the inverse S-box (InvSubBytes, FIPS-197) to all 16 bytes of a 128-bit state.
- A per-transaction mode bit selects forward or inverse substitution.
- Result is registered: one cycle of latency, with a valid flag.

---
 rtl/aes_sub_bytes_unit_pkg.sv | 44 ++++
 rtl/aes_sub_bytes_unit_if.sv | 13 +
 rtl/aes_sbox_byte.sv | 20 ++
 rtl/aes_sub_bytes_unit.sv | 42 ++++
 tb/tb_aes_sub_bytes_unit.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/aes_sub_bytes_unit_pkg.sv
// rtl/aes_sub_bytes_unit_pkg.sv - shared AES types, constants and GF(2^8) helpers
package aes_sub_bytes_unit_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    localparam byte_t GF_POLY = 8'h1B;
    localparam byte_t AFF_FWD = 8'h63;
    localparam byte_t AFF_INV = 8'h05;

    function automatic byte_t gf_xtime(byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic byte_t gf_mul(byte_t a, byte_t b);
        byte_t p = 8'h00;
        byte_t s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ s;
            s = gf_xtime(s);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); maps 0 to 0 without a special case.
    function automatic byte_t gf_inv(byte_t x);
        byte_t sq = x;
        byte_t r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic byte_t affine_fwd(byte_t b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ AFF_FWD;
    endfunction

    function automatic byte_t affine_inv(byte_t b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ AFF_INV;
    endfunction

endpackage

// File: rtl/aes_sub_bytes_unit_if.sv
// rtl/aes_sub_bytes_unit_if.sv - request/result bundle for the SubBytes stage
interface aes_sub_bytes_unit_if;
    logic         in_valid;
    logic         in_inv;
    logic [127:0] in_data;
    logic         out_valid;
    logic [127:0] out_data;

    modport master (output in_valid, output in_inv, output in_data,
                    input  out_valid, input out_data);
    modport slave  (input  in_valid, input in_inv, input in_data,
                    output out_valid, output out_data);
endinterface

// File: rtl/aes_sbox_byte.sv
// rtl/aes_sbox_byte.sv - combinational forward/inverse S-box sharing one GF inverter
module aes_sbox_byte
    import aes_sub_bytes_unit_pkg::*;
(
    input  byte_t in_byte,
    input  logic  inv,
    output byte_t out_byte
);

    byte_t pre;
    byte_t ginv;

    // Inverse path runs the inverse affine before the inverter, forward path after.
    always_comb begin
        pre      = inv ? affine_inv(in_byte) : in_byte;
        ginv     = gf_inv(pre);
        out_byte = inv ? ginv : affine_fwd(ginv);
    end

endmodule

// File: rtl/aes_sub_bytes_unit.sv
// rtl/aes_sub_bytes_unit.sv - registered 16-lane SubBytes / InvSubBytes stage
module aes_sub_bytes_unit
    import aes_sub_bytes_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    aes_sub_bytes_unit_if.slave   io
);

    state_t sub_state;
    state_t out_data_d;
    state_t out_data_q;
    logic   out_valid_d;
    logic   out_valid_q;

    for (genvar k = 0; k < 16; k++) begin : g_lane
        aes_sbox_byte u_sbox (
            .in_byte  (io.in_data[8*k +: 8]),
            .inv      (io.in_inv),
            .out_byte (sub_state[8*k +: 8])
        );
    end

    always_comb begin
        out_valid_d = io.in_valid;
        out_data_d  = io.in_valid ? sub_state : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;

endmodule

// File: tb/tb_aes_sub_bytes_unit.sv
// tb/tb_aes_sub_bytes_unit.sv - self-checking bench for aes_sub_bytes_unit
module tb_aes_sub_bytes_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    aes_sub_bytes_unit_if bus ();

    aes_sub_bytes_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         inv;
        logic [127:0] data;
        logic [127:0] expect_data;
    } vec_t;

    logic [7:0] sbox_ref [256];
    logic [7:0] isbox_ref [256];

    function automatic logic [7:0] ref_mul(logic [7:0] a, logic [7:0] b);
        logic [15:0] p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int d = 14; d >= 8; d--)
            if (p[d]) p = p ^ (16'h011B << (d - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_ginv(logic [7:0] x);
        if (x == 8'h00) return 8'h00;
        for (int y = 1; y < 256; y++)
            if (ref_mul(x, 8'(y)) == 8'h01) return 8'(y);
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_sbox(logic [7:0] x);
        logic [7:0] t = ref_ginv(x);
        logic [7:0] c = 8'h63;
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = t[i] ^ t[(i+4)%8] ^ t[(i+5)%8] ^ t[(i+6)%8] ^ t[(i+7)%8] ^ c[i];
        return r;
    endfunction

    function automatic logic [127:0] ref_state(logic [127:0] d, logic inv);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = inv ? isbox_ref[d[8*k +: 8]] : sbox_ref[d[8*k +: 8]];
        return r;
    endfunction

    task automatic check(string name, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply_one(logic inv, logic [127:0] data);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_inv   = inv;
        bus.in_data  = data;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    vec_t       vecs [5];
    logic [127:0] exp_q [$];
    logic [127:0] d;
    logic [127:0] last;
    logic [7:0]   f;
    bit           seen [256];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_inv   = 1'b0;
        bus.in_data  = '0;

        for (int x = 0; x < 256; x++) sbox_ref[x] = ref_sbox(8'(x));
        for (int x = 0; x < 256; x++) isbox_ref[sbox_ref[x]] = 8'(x);

        vecs[0] = '{"fwd_spot", 1'b0, 128'h000000000000000000000000FF530100,
                    128'h63636363636363636363636316ED7C63};
        vecs[1] = '{"fips_fwd", 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                    128'hd42711aee0bf98f1b8b45de51e415230};
        vecs[2] = '{"fips_inv", 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230,
                    128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vecs[3] = '{"inv_all63", 1'b1, {16{8'h63}}, 128'h0};
        vecs[4] = '{"inv_spot", 1'b1, 128'h636363636363636363636363636316ED,
                    128'h0000000000000000000000000000FF53};

        #12;
        check("reset_valid", 128'(bus.out_valid), 128'h0);
        check("reset_data", bus.out_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apply_one(vecs[i].inv, vecs[i].data);
            check({vecs[i].name, "_valid"}, 128'(bus.out_valid), 128'h1);
            check(vecs[i].name, bus.out_data, vecs[i].expect_data);
            check({vecs[i].name, "_model"}, ref_state(vecs[i].data, vecs[i].inv), vecs[i].expect_data);
        end

        for (int x = 0; x < 256; x++) seen[x] = 1'b0;
        for (int x = 0; x < 256; x++) begin
            apply_one(1'b0, {16{8'(x)}});
            check("rt_fwd", bus.out_data, {16{sbox_ref[x]}});
            f = bus.out_data[7:0];
            check("rt_distinct", 128'(seen[f]), 128'h0);
            seen[f] = 1'b1;
            apply_one(1'b1, bus.out_data);
            check("rt_inv", bus.out_data, {16{8'(x)}});
        end

        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("stream_valid", 128'(bus.out_valid), 128'h1);
                check("stream_data", bus.out_data, exp_q.pop_front());
            end
            if (i < 20) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                bus.in_valid = 1'b1;
                bus.in_inv   = i[0];
                bus.in_data  = d;
                last = ref_state(d, i[0]);
                exp_q.push_back(last);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_inv   = 1'b1;
                bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        @(negedge clk);
        check("idle_valid", 128'(bus.out_valid), 128'h0);
        check("idle_hold", bus.out_data, last);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(bus.out_valid), 128'h0);
        check("async_rst_data", bus.out_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_one(1'b0, 128'h0);
        check("post_rst", bus.out_data, {16{8'h63}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
